wide_alu_seq: RTL and testbench

Multi-word add/subtract sequencer for the shared 32-bit ALU. It accepts an operation on operands WORDS×WIDTH bits wide and drives the ALU one word per cycle, least-significant word first. It chains the carry through the ALU's carry-in opcodes and assembles the wide result and flags. It sits between the execute-stage control and the ALU's control/operand inputs, and owns the ALU while busy.

---
 rtl/wide_alu_seq_if.sv | 37 +++
 rtl/wide_alu_seq.sv | 116 +++++++++++
 tb/tb_wide_alu_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wide_alu_seq_if.sv
// Bundle between execute-stage control, the wide add/sub sequencer and the shared ALU.
// Handshake: start is accepted only while busy is low; done pulses once when result and flags are valid.
interface wide_alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int WORDS = 2
);
  localparam int N = WIDTH * WORDS;

  logic             start;
  logic             op;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;
  logic             co;
  logic             ovf;
  logic             z;
  logic             n;
  logic [3:0]       alu_control;
  logic             alu_ci;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_co;
  logic             alu_ovf;

  modport slave (
    input  start, op, a, b, alu_out, alu_co, alu_ovf,
    output busy, done, result, co, ovf, z, n, alu_control, alu_ci, alu_a, alu_b
  );

  modport master (
    output start, op, a, b, alu_out, alu_co, alu_ovf,
    input  busy, done, result, co, ovf, z, n, alu_control, alu_ci, alu_a, alu_b
  );
endinterface

// File: rtl/wide_alu_seq.sv
// Multi-word add/subtract sequencer: drives the shared ALU one word per cycle, LSW first,
// chaining carry through the carry-in opcodes and assembling the wide result and flags.
module wide_alu_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 2
) (
  input  logic          clk,
  input  logic          reset,
  wide_alu_seq_if.slave bus,
  output logic [1:0]    dbg_state_o
);
  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, b_q, result_q;
  logic            op_q, carry_q, zacc_q;
  logic            co_q, ovf_q, z_q, n_q;
  logic [IDXW-1:0] idx_q;
  logic            zacc_next;
  int              wsel;

  assign wsel      = int'(idx_q) * WIDTH;
  assign zacc_next = zacc_q & (bus.alu_out == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.alu_control = 4'b0000;
    bus.alu_ci      = 1'b0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    if (state_q == S_RUN) begin
      bus.alu_a = a_q[wsel +: WIDTH];
      bus.alu_b = b_q[wsel +: WIDTH];
      if (idx_q == '0) begin
        bus.alu_control = op_q ? 4'b0010 : 4'b0100;
      end else begin
        bus.alu_control = op_q ? 4'b0110 : 4'b0101;
        bus.alu_ci      = carry_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            carry_q <= 1'b0;
            // Accumulator starts at 1 so it ANDs down to "all words zero".
            zacc_q  <= 1'b1;
          end
        end
        S_RUN: begin
          result_q[wsel +: WIDTH] <= bus.alu_out;
          carry_q <= bus.alu_co;
          zacc_q  <= zacc_next;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            co_q  <= bus.alu_co;
            ovf_q <= bus.alu_ovf;
            n_q   <= bus.alu_out[WIDTH-1];
            z_q   <= zacc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.co      = co_q;
  assign bus.ovf     = ovf_q;
  assign bus.z       = z_q;
  assign bus.n       = n_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq: behavioural ALU, wide-arithmetic reference model, directed and random ops.
module tb_wide_alu_seq;
  localparam int W     = 32;
  localparam int WORDS = 2;
  localparam int N     = W * WORDS;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         vectors;
  int         miscompares;
  logic [4:0] trace_q[$];

  wide_alu_seq_if #(.WIDTH(W), .WORDS(WORDS)) bus ();

  wide_alu_seq #(.WIDTH(W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: combinational add/sub with the four opcodes used by the sequencer.
  logic [W:0]   alu_s;
  logic [W-1:0] alu_bb;
  logic         alu_cin;
  always_comb begin
    alu_bb  = bus.alu_b;
    alu_cin = 1'b0;
    case (bus.alu_control)
      4'b0101: alu_cin = bus.alu_ci;
      4'b0010: begin alu_bb = ~bus.alu_b; alu_cin = 1'b1; end
      4'b0110: begin alu_bb = ~bus.alu_b; alu_cin = bus.alu_ci; end
      default: ;
    endcase
    alu_s       = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {{W{1'b0}}, alu_cin};
    bus.alu_out = alu_s[W-1:0];
    bus.alu_co  = alu_s[W];
    bus.alu_ovf = (bus.alu_a[W-1] == alu_bb[W-1]) && (alu_s[W-1] != bus.alu_a[W-1]);
  end

  always @(negedge clk) begin
    if (bus.alu_control != 4'b0000) trace_q.push_back({bus.alu_ci, bus.alu_control});
  end

  // Returns {co, ovf, z, n, result} computed on the full-width operands.
  function automatic logic [N+3:0] ref_op(input logic o, input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    if (!o) begin
      s = {1'b0, av} + {1'b0, bv};
      r = s[N-1:0];
      c = s[N];
      v = (av[N-1] == bv[N-1]) && (r[N-1] != av[N-1]);
    end else begin
      s = {1'b0, av} - {1'b0, bv};
      r = s[N-1:0];
      c = ~s[N];
      v = (av[N-1] != bv[N-1]) && (r[N-1] != av[N-1]);
    end
    return {c, v, (r == '0), r[N-1], r};
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) r[i*W +: W] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [N+3:0] e);
    check({tag, "_result"}, 128'(bus.result), 128'(e[N-1:0]));
    check({tag, "_co"},     128'(bus.co),     128'(e[N+3]));
    check({tag, "_ovf"},    128'(bus.ovf),    128'(e[N+2]));
    check({tag, "_z"},      128'(bus.z),      128'(e[N+1]));
    check({tag, "_n"},      128'(bus.n),      128'(e[N]));
  endtask

  task automatic run_op(input string tag, input logic o, input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N+3:0] e;
    int cyc;
    e = ref_op(o, av, bv);
    trace_q.delete();
    @(negedge clk);
    bus.op = o; bus.a = av; bus.b = bv; bus.start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.op    = 1'($urandom());
        bus.a     = rand_wide();
        bus.b     = rand_wide();
      end
    end while (!bus.done && cyc < 20);
    check({tag, "_latency"}, 128'(cyc), 128'(WORDS + 1));
    check_flags(tag, e);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
    check({tag, "_busy_drop"},  128'(bus.busy), 128'(0));
    check({tag, "_hold"},       128'(bus.result), 128'(e[N-1:0]));
  endtask

  initial begin
    logic [N-1:0] a1, b1, a2, b2;
    logic         o1, o2;
    logic [N+3:0] e1, e2;
    int           cyc, t1, dones;

    vectors = 0; miscompares = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   128'(bus.busy),   128'(0));
    check("rst_done",   128'(bus.done),   128'(0));
    check("rst_result", 128'(bus.result), 128'(0));
    check("rst_flags",  128'({bus.co, bus.ovf, bus.z, bus.n}), 128'(0));
    check("rst_alu",    128'({bus.alu_control, bus.alu_ci, bus.alu_a, bus.alu_b}), 128'(0));
    @(negedge clk); reset = 1'b0;

    run_op("add_carry", 1'b0, 64'h00000000_FFFFFFFF, 64'h00000000_00000001);
    check("add_carry_trace_len", 128'(trace_q.size()), 128'(2));
    check("add_carry_trace0", 128'(trace_q[0]), 128'(5'b0_0100));
    check("add_carry_trace1", 128'(trace_q[1]), 128'(5'b1_0101));

    run_op("sub_borrow", 1'b1, 64'h00000001_00000000, 64'h00000000_00000001);
    check("sub_borrow_trace_len", 128'(trace_q.size()), 128'(2));
    check("sub_borrow_trace0", 128'(trace_q[0]), 128'(5'b0_0010));
    check("sub_borrow_trace1", 128'(trace_q[1]), 128'(5'b0_0110));

    run_op("sub_0_1",  1'b1, 64'h0, 64'h1);
    run_op("add_ovf",  1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1);
    run_op("add_wrap", 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1);
    run_op("sub_eq",   1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom()), rand_wide(), rand_wide());
    end

    // start held high: second operand set applied mid-RUN of the first op.
    o1 = 1'($urandom()); a1 = rand_wide(); b1 = rand_wide();
    o2 = 1'($urandom()); a2 = rand_wide(); b2 = rand_wide();
    e1 = ref_op(o1, a1, b1);
    e2 = ref_op(o2, a2, b2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o1; bus.a = a1; bus.b = b1;
    @(posedge clk); #1;
    bus.op = o2; bus.a = a2; bus.b = b2;
    cyc = 1;
    while (!bus.done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("b2b_first_latency", 128'(cyc), 128'(WORDS + 1));
    check_flags("b2b_first", e1);
    t1 = cyc;
    @(posedge clk); #1; cyc++;
    while (!bus.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    bus.start = 1'b0;
    check("b2b_period", 128'(cyc - t1), 128'(WORDS + 2));
    check_flags("b2b_second", e2);
    repeat (3) @(posedge clk);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = rand_wide() | 64'h1; bus.b = rand_wide();
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("abort_busy",   128'(bus.busy),   128'(0));
    check("abort_done",   128'(bus.done),   128'(0));
    check("abort_result", 128'(bus.result), 128'(0));
    check("abort_flags",  128'({bus.co, bus.ovf, bus.z, bus.n}), 128'(0));
    check("abort_alu",    128'({bus.alu_control, bus.alu_ci, bus.alu_a, bus.alu_b}), 128'(0));
    dones = 0;
    repeat (10) begin @(posedge clk); #1; if (bus.done || bus.busy) dones++; end
    check("abort_no_done", 128'(dones), 128'(0));

    run_op("after_abort", 1'b1, rand_wide(), rand_wide());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
